rv_multicycle_ctrl: RTL and testbench

Control FSM that sequences the shared RV32I datapath (register file, immediate generator, ALU, PC) over several cycles per instruction instead of one.
- Handshakes with instruction and data memories (req/ack).
- Drives the IR/PC/register write enables and the datapath mux selects.
- Traps on unsupported opcodes and on memory timeouts.
- Sits between the decoder's opcode field and every datapath write enable.

---
 rtl/rv_ctrl_pkg.sv | 47 ++++
 rtl/rv_multicycle_ctrl_if.sv | 11 +
 rtl/rv_op_class.sv | 23 ++
 rtl/rv_multicycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and encodings for the RV32I multicycle control FSM
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_ILLEGAL = 2'd1,
    TRAP_IMEM_TO = 2'd2,
    TRAP_DMEM_TO = 2'd3
  } trap_cause_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_PC_IMM = 2'd1;
  localparam logic [1:0] PC_RS1_IMM = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// rtl/rv_multicycle_ctrl_if.sv - instruction/data memory req/ack handshake bundle
interface rv_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/rv_op_class.sv
// rtl/rv_op_class.sv - combinational RV32I opcode to instruction class mapping
module rv_op_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_R:      op_class = CLS_R;
      OPC_I:      op_class = CLS_I;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_JAL:    op_class = CLS_JAL;
      OPC_JALR:   op_class = CLS_JALR;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - multicycle RV32I control FSM with memory handshakes and traps
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  rv_multicycle_ctrl_if.master mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 alu_src_imm,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 retire,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state_dbg
);

  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam int CW = TO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Trap fires when the count would reach MEM_TIMEOUT, i.e. after MEM_TIMEOUT unacked cycles.
  localparam logic [CW-1:0] LIMIT = CW'(TO_EN ? MEM_TIMEOUT - 1 : 0);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  logic [CW-1:0] wait_q, wait_d;
  op_class_e   cls;
  logic        timeout_hit;

  logic imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c;
  logic alu_src_imm_c, reg_we_c, retire_c, trap_c;
  logic [1:0] pc_sel_c, wb_sel_c;

  rv_op_class u_op_class (
    .opcode   (opcode),
    .op_class (cls)
  );

  assign timeout_hit = TO_EN && (wait_q == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cause_q <= TRAP_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    wait_d        = '0;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    ir_we_c       = 1'b0;
    pc_we_c       = 1'b0;
    pc_sel_c      = PC_PLUS4;
    alu_src_imm_c = 1'b0;
    reg_we_c      = 1'b0;
    wb_sel_c      = WB_ALU;
    retire_c      = 1'b0;
    trap_c        = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ack) begin
          ir_we_c = 1'b1;
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = TRAP_IMEM_TO;
        end else begin
          wait_d = TO_EN ? wait_q + 1'b1 : '0;
        end
      end
      DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          state_d = TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_src_imm_c = (cls == CLS_I) || (cls == CLS_LOAD) ||
                        (cls == CLS_STORE) || (cls == CLS_JALR);
        case (cls)
          CLS_LOAD, CLS_STORE: state_d = MEM;
          CLS_BRANCH: begin
            pc_we_c  = 1'b1;
            pc_sel_c = branch_taken ? PC_PC_IMM : PC_PLUS4;
            retire_c = 1'b1;
            state_d  = FETCH;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls == CLS_STORE);
        if (mem.dmem_ack) begin
          if (cls == CLS_STORE) begin
            pc_we_c  = 1'b1;
            pc_sel_c = PC_PLUS4;
            retire_c = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = TRAP_DMEM_TO;
        end else begin
          wait_d = TO_EN ? wait_q + 1'b1 : '0;
        end
      end
      WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        retire_c = 1'b1;
        state_d  = FETCH;
        case (cls)
          CLS_LOAD: wb_sel_c = WB_LOAD;
          CLS_JAL: begin
            wb_sel_c = WB_PC4;
            pc_sel_c = PC_PC_IMM;
          end
          CLS_JALR: begin
            wb_sel_c = WB_PC4;
            pc_sel_c = PC_RS1_IMM;
          end
          default: wb_sel_c = WB_ALU;
        endcase
      end
      TRAP: trap_c = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  // Reset masks every output so an aborted instruction leaves no partial writes behind.
  assign mem.imem_req = imem_req_c & ~rst;
  assign mem.dmem_req = dmem_req_c & ~rst;
  assign mem.dmem_we  = dmem_we_c & ~rst;
  assign ir_we        = ir_we_c & ~rst;
  assign pc_we        = pc_we_c & ~rst;
  assign pc_sel       = rst ? 2'd0 : pc_sel_c;
  assign alu_src_imm  = alu_src_imm_c & ~rst;
  assign reg_we       = reg_we_c & ~rst;
  assign wb_sel       = rst ? 2'd0 : wb_sel_c;
  assign retire       = retire_c & ~rst;
  assign trap         = trap_c & ~rst;
  assign trap_cause   = rst ? 2'd0 : cause_q;
  assign state_dbg    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - randomized self-checking bench for rv_multicycle_ctrl
module tb_rv_multicycle_ctrl;

  localparam int TO = 4;
  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011;
  localparam logic [6:0] O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111, O_LUI = 7'b0110111;

  typedef struct packed {
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic alu_src_imm, reg_we;
    logic [1:0] wb_sel;
    logic retire, trap;
    logic [1:0] trap_cause;
  } out_t;

  typedef struct packed {
    logic [6:0] op;
    logic bt, iack, dack;
    out_t exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode;
  logic branch_taken;
  logic ir_we, pc_we, alu_src_imm, reg_we, retire, trap;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;
  cyc_t q[$];

  always #5 clk = ~clk;

  rv_multicycle_ctrl_if mem ();

  rv_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem(mem),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .trap(trap),
    .trap_cause(trap_cause), .state_dbg(state_dbg)
  );

  function automatic out_t sample();
    out_t o;
    o.imem_req = mem.imem_req;  o.dmem_req = mem.dmem_req;  o.dmem_we = mem.dmem_we;
    o.ir_we = ir_we;  o.pc_we = pc_we;  o.pc_sel = pc_sel;  o.alu_src_imm = alu_src_imm;
    o.reg_we = reg_we;  o.wb_sel = wb_sel;  o.retire = retire;  o.trap = trap;
    o.trap_cause = trap_cause;
    return o;
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    return op inside {O_R, O_I, O_LD, O_ST, O_BR, O_JAL, O_JALR};
  endfunction

  // A cycle where the instruction is off the memory bus: random spurious acks must be ignored.
  function automatic cyc_t quiet(logic [6:0] op);
    cyc_t c;
    c = '0;
    c.op = op;
    c.bt = 1'($urandom);
    c.iack = 1'($urandom);
    c.dack = 1'($urandom);
    return c;
  endfunction

  task automatic push_trap(input logic [1:0] cause);
    cyc_t c;
    for (int k = 0; k < 5; k++) begin
      c = quiet(7'($urandom));
      c.exp.trap = 1'b1;
      c.exp.trap_cause = cause;
      q.push_back(c);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction; a delay of -1 means never acked.
  task automatic model_instr(input logic [6:0] op, input logic bt, input int di, input int dd);
    cyc_t c;
    bit ld, st, br, jal, jalr, imm;
    int n;
    ld = (op == O_LD);  st = (op == O_ST);  br = (op == O_BR);
    jal = (op == O_JAL);  jalr = (op == O_JALR);  imm = (op == O_I);
    n = (di < 0) ? TO : di;
    for (int k = 0; k < n; k++) begin
      c = quiet(7'($urandom));
      c.iack = 1'b0;
      c.exp.imem_req = 1'b1;
      q.push_back(c);
    end
    if (di < 0) begin
      push_trap(2'd2);
      return;
    end
    c = quiet(7'($urandom));
    c.iack = 1'b1;
    c.exp.imem_req = 1'b1;
    c.exp.ir_we = 1'b1;
    q.push_back(c);
    q.push_back(quiet(op));
    if (!is_legal(op)) begin
      push_trap(2'd1);
      return;
    end
    c = quiet(op);
    c.exp.alu_src_imm = imm | ld | st | jalr;
    if (br) begin
      c.bt = bt;
      c.exp.pc_we = 1'b1;
      c.exp.pc_sel = bt ? 2'd1 : 2'd0;
      c.exp.retire = 1'b1;
      q.push_back(c);
      return;
    end
    q.push_back(c);
    if (ld || st) begin
      n = (dd < 0) ? TO : dd;
      for (int k = 0; k <= n; k++) begin
        c = quiet(op);
        c.dack = 1'b0;
        c.exp.dmem_req = 1'b1;
        c.exp.dmem_we = st;
        if (k == n && dd >= 0) begin
          c.dack = 1'b1;
          c.exp.pc_we = st;
          c.exp.retire = st;
        end
        if (k < n || dd >= 0) q.push_back(c);
      end
      if (dd < 0) begin
        push_trap(2'd3);
        return;
      end
      if (st) return;
    end
    c = quiet(op);
    c.exp.reg_we = 1'b1;
    c.exp.pc_we = 1'b1;
    c.exp.retire = 1'b1;
    c.exp.wb_sel = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
    c.exp.pc_sel = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
    q.push_back(c);
  endtask

  // Called at a negedge; each entry drives one cycle and is checked 1 time unit later.
  task automatic run_q(input string name, input int limit);
    cyc_t c;
    out_t o;
    int cyc = 0;
    while (q.size() > 0 && (limit < 0 || cyc < limit)) begin
      c = q.pop_front();
      opcode = c.op;
      branch_taken = c.bt;
      mem.imem_ack = c.iack;
      mem.dmem_ack = c.dack;
      #1;
      o = sample();
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h", name, cyc + 1, o, c.exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (sample() !== out_t'(0) || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL %s: got %h state %0d want all zero", name, sample(), state_dbg);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem.imem_ack = 1'b1;
    mem.dmem_ack = 1'b1;
    #1;
    check_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_addi();
    model_instr(O_I, 1'b0, 0, 0);
    run_q("addi", -1);
  endtask

  task automatic test_load_delay();
    model_instr(O_LD, 1'b0, 0, 3);
    run_q("load_delay", -1);
  endtask

  task automatic test_branch();
    model_instr(O_BR, 1'b1, 0, 0);
    model_instr(O_BR, 1'b0, 0, 0);
    run_q("branch", -1);
  endtask

  task automatic test_jalr_store();
    model_instr(O_JALR, 1'b0, 1, 0);
    model_instr(O_ST, 1'b0, 0, 2);
    model_instr(O_JAL, 1'b0, 2, 0);
    run_q("jalr_store", -1);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [7];
    ops = '{O_R, O_I, O_LD, O_ST, O_BR, O_JAL, O_JALR};
    for (int i = 0; i < 40; i++)
      model_instr(ops[$urandom_range(0, 6)], 1'($urandom), $urandom_range(0, TO - 1),
                  $urandom_range(0, TO - 1));
    run_q("back_to_back", -1);
  endtask

  task automatic test_illegal();
    logic [6:0] op;
    do_reset();
    model_instr(O_LUI, 1'b0, 0, 0);
    run_q("illegal_lui", -1);
    for (int i = 0; i < 3; i++) begin
      do_reset();
      do op = 7'($urandom); while (is_legal(op));
      model_instr(op, 1'b0, $urandom_range(0, 2), 0);
      run_q("illegal_rand", -1);
    end
    do_reset();
    model_instr(O_I, 1'b0, 0, 0);
    run_q("after_trap_reset", -1);
  endtask

  task automatic test_timeout();
    do_reset();
    model_instr(O_I, 1'b0, -1, 0);
    run_q("imem_timeout", -1);
    do_reset();
    model_instr(O_LD, 1'b0, 0, -1);
    run_q("dmem_timeout", -1);
    do_reset();
    model_instr(O_R, 1'b0, TO - 1, 0);
    model_instr(O_ST, 1'b0, 0, TO - 1);
    run_q("ack_at_limit", -1);
  endtask

  task automatic test_reset_midway();
    cyc_t c;
    do_reset();
    model_instr(O_R, 1'b0, 0, 0);
    run_q("midway_pre", 3);
    c = q.pop_front();
    opcode = c.op;
    branch_taken = c.bt;
    rst = 1'b1;
    #1;
    check_zero("midway_abort");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_instr(O_I, 1'b0, 0, 0);
    run_q("midway_restart", -1);
  endtask

  initial begin
    rst = 1'b1;
    opcode = '0;
    branch_taken = 1'b0;
    mem.imem_ack = 1'b0;
    mem.dmem_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_load_delay();
    test_branch();
    test_jalr_store();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
